// File: rtl/level_meter_pkg.sv
// Shared definitions for the level meter: level width, peak FSM state codes
// and the signed-to-unsigned level clamp.
package level_meter_pkg;

  localparam int LEVEL_W = 10;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t HOLD  = 2'd1;
  localparam state_t DECAY = 2'd2;

  // Negative amplitudes read as silence; positive ones already fit in 9 bits.
  function automatic logic [LEVEL_W-1:0] clamp_level(input logic [LEVEL_W-1:0] v);
    return v[LEVEL_W-1] ? '0 : {1'b0, v[LEVEL_W-2:0]};
  endfunction

endpackage

// File: rtl/level_meter_pixel_gen.sv
// Bar / peak-marker comparator for one vertical meter column.
// Latency: flags registered one cycle after pix_x/pix_y. No backpressure.
module level_meter_pixel_gen
  import level_meter_pkg::*;
#(
  parameter int unsigned X_LEFT   = 100,
  parameter int unsigned X_RIGHT  = 120,
  parameter int unsigned Y_BOTTOM = 460
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [LEVEL_W-1:0] level_q,
  input  logic [LEVEL_W-1:0] peak_q,
  input  logic [9:0]         pix_x,
  input  logic [9:0]         pix_y,
  output logic               bar_on,
  output logic               peak_on
);

  localparam logic [9:0] XL = 10'(X_LEFT);
  localparam logic [9:0] XR = 10'(X_RIGHT);
  localparam logic [9:0] YB = 10'(Y_BOTTOM);

  logic             inx;
  logic [9:0]       bar_h;
  logic [9:0]       peak_h;
  logic             bar_d;
  logic             peak_d;

  // Bar height is half the level so the full 0..511 range spans 256 rows.
  assign bar_h  = level_q >> 1;
  assign peak_h = peak_q >> 1;
  assign inx    = (pix_x >= XL) && (pix_x < XR);

  // YB >= 255 keeps YB - height non-negative for every legal level.
  assign bar_d  = inx && (bar_h != '0) && (pix_y <= YB) && (pix_y > (YB - bar_h));
  assign peak_d = inx && (peak_q != '0) && (pix_y == (YB - peak_h));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bar_on  <= 1'b0;
      peak_on <= 1'b0;
    end else begin
      bar_on  <= bar_d;
      peak_on <= peak_d;
    end
  end

endmodule

// File: rtl/level_meter_peak_hold.sv
// Per-frame level capture with hold-then-decay peak tracking, clip flag and bar/marker pixel flags.
// Latency: level/peak/clip update on the vsync edge; pixel flags one cycle after pix_x/pix_y. No backpressure.
module level_meter_peak_hold
  import level_meter_pkg::*;
#(
  parameter int unsigned HOLD_FRAMES = 30,
  parameter int unsigned DECAY_STEP  = 4,
  parameter int unsigned CLIP_LEVEL  = 480,
  parameter int unsigned X_LEFT      = 100,
  parameter int unsigned X_RIGHT     = 120,
  parameter int unsigned Y_BOTTOM    = 460
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [LEVEL_W-1:0] level_in,
  input  logic               vsync_pulse,
  input  logic [9:0]         pix_x,
  input  logic [9:0]         pix_y,
  output logic [LEVEL_W-1:0] level_q,
  output logic [LEVEL_W-1:0] peak_q,
  output logic               bar_on,
  output logic               peak_on,
  output logic               clip
);

  localparam logic [7:0]         HOLD_INIT = 8'(HOLD_FRAMES);
  localparam logic [LEVEL_W-1:0] STEP      = LEVEL_W'(DECAY_STEP);
  localparam logic [LEVEL_W-1:0] CLIP_TH   = LEVEL_W'(CLIP_LEVEL);

  state_t             state;
  state_t             state_nxt;
  logic [7:0]         hold_cnt;
  logic [7:0]         hold_nxt;
  logic [LEVEL_W-1:0] peak_nxt;
  logic [LEVEL_W-1:0] lvl_c;
  logic [LEVEL_W-1:0] decay_d;

  assign lvl_c   = clamp_level(level_in);
  assign decay_d = (peak_q >= STEP) ? (peak_q - STEP) : '0;

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    peak_nxt  = peak_q;
    if (vsync_pulse) begin
      if (lvl_c > peak_q) begin
        peak_nxt  = lvl_c;
        hold_nxt  = HOLD_INIT;
        state_nxt = HOLD;
      end else begin
        case (state)
          IDLE: peak_nxt = lvl_c;
          HOLD: begin
            if (hold_cnt > 8'd1) begin
              hold_nxt = hold_cnt - 8'd1;
            end else begin
              hold_nxt  = '0;
              state_nxt = DECAY;
            end
          end
          DECAY: begin
            // Decay stops once it meets the live level; the meter then follows it in IDLE.
            if (decay_d > lvl_c) begin
              peak_nxt = decay_d;
            end else begin
              peak_nxt  = lvl_c;
              state_nxt = IDLE;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q  <= '0;
      peak_q   <= '0;
      hold_cnt <= '0;
      state    <= IDLE;
      clip     <= 1'b0;
    end else begin
      if (vsync_pulse) begin
        level_q <= lvl_c;
      end
      peak_q   <= peak_nxt;
      hold_cnt <= hold_nxt;
      state    <= state_nxt;
      clip     <= (peak_nxt >= CLIP_TH);
    end
  end

  level_meter_pixel_gen #(
    .X_LEFT   (X_LEFT),
    .X_RIGHT  (X_RIGHT),
    .Y_BOTTOM (Y_BOTTOM)
  ) u_pixel_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .level_q (level_q),
    .peak_q  (peak_q),
    .pix_x   (pix_x),
    .pix_y   (pix_y),
    .bar_on  (bar_on),
    .peak_on (peak_on)
  );

endmodule
